// File: rtl/fsmc_fifo_regbank.sv
// fsmc_fifo_regbank
// Register bank sitting behind the synchronous FSMC slave interface. Decodes
// single-cycle wen/ren strobes into control/status registers, a scratch
// register and two circular-buffer FIFOs (TX: MCU -> fabric, RX: fabric -> MCU).
// Read data is registered and valid one clock after ren.
//
// Build option: define FSMC_REGBANK_IRQ_EN to implement the CTRL interrupt
// enables (bits 2-3) and the registered level interrupt. When undefined, irq is
// tied low and CTRL bits 2-3 read as zero.

// Circular-buffer FIFO shared by the TX and RX paths.
// Push is accepted only when not full, pop only when not empty; flush wins.
module fsmc_fifo_regbank_fifo #(
  parameter int p_WIDTH = 16,
  parameter int p_AW    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [p_WIDTH-1:0] push_data,
  input  logic               pop,
  output logic [p_WIDTH-1:0] head,
  output logic [p_AW:0]      count,
  output logic               full,
  output logic               empty
);

  localparam logic [p_AW:0]   CNT_FULL = {1'b1, {p_AW{1'b0}}};
  localparam logic [p_AW:0]   CNT_ONE  = (p_AW+1)'(1);
  localparam logic [p_AW-1:0] PTR_ONE  = p_AW'(1);

  logic [p_WIDTH-1:0] mem [2**p_AW];
  logic [p_AW-1:0]    wptr_q, wptr_d;
  logic [p_AW-1:0]    rptr_q, rptr_d;
  logic [p_AW:0]      cnt_q, cnt_d;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (cnt_q == CNT_FULL);
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rptr_q];
  assign count   = cnt_q;

  // Next pointers and occupancy; flush overrides any push or pop this cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PTR_ONE;
      if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage write port.
  // NOTE: the array has no reset; an entry is only ever read after a push has written it.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wptr_q] <= push_data;
  end

endmodule

module fsmc_fifo_regbank #(
  parameter int p_WIDTH_ADDR = 8,
  parameter int p_WIDTH_DATA = 16,
  parameter int p_FIFO_AW    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [p_WIDTH_ADDR-1:0] addr,
  input  logic [p_WIDTH_DATA-1:0] wdata,
  input  logic                    wen,
  input  logic                    ren,
  output logic [p_WIDTH_DATA-1:0] rdata,
  output logic [p_WIDTH_DATA-1:0] tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic [p_WIDTH_DATA-1:0] rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic                    irq
);

  // Word addresses; decodes compare the full address width.
  localparam logic [p_WIDTH_ADDR-1:0] ADDR_CTRL     = p_WIDTH_ADDR'(0);
  localparam logic [p_WIDTH_ADDR-1:0] ADDR_STATUS   = p_WIDTH_ADDR'(1);
  localparam logic [p_WIDTH_ADDR-1:0] ADDR_TX_DATA  = p_WIDTH_ADDR'(2);
  localparam logic [p_WIDTH_ADDR-1:0] ADDR_RX_DATA  = p_WIDTH_ADDR'(3);
  localparam logic [p_WIDTH_ADDR-1:0] ADDR_TX_LEVEL = p_WIDTH_ADDR'(4);
  localparam logic [p_WIDTH_ADDR-1:0] ADDR_RX_LEVEL = p_WIDTH_ADDR'(5);
  localparam logic [p_WIDTH_ADDR-1:0] ADDR_SCRATCH  = p_WIDTH_ADDR'(6);

  // Bus decode strobes.
  logic wr_ctrl, wr_status, wr_tx_data, wr_scratch, rd_rx_data;
  logic tx_flush, rx_flush;

  assign wr_ctrl    = wen && (addr == ADDR_CTRL);
  assign wr_status  = wen && (addr == ADDR_STATUS);
  assign wr_tx_data = wen && (addr == ADDR_TX_DATA);
  assign wr_scratch = wen && (addr == ADDR_SCRATCH);
  assign rd_rx_data = ren && (addr == ADDR_RX_DATA);

  // Flush bits are strobes only; they are never stored, so they read back 0.
  assign tx_flush = wr_ctrl && wdata[0];
  assign rx_flush = wr_ctrl && wdata[1];

  // FIFO status.
  logic [p_WIDTH_DATA-1:0] rx_head;
  logic [p_FIFO_AW:0]      tx_cnt, rx_cnt;
  logic                    tx_full, tx_empty, rx_full, rx_empty;

  // TX: MCU pushes through TX_DATA writes, fabric pops with tx_ready.
  fsmc_fifo_regbank_fifo #(
    .p_WIDTH (p_WIDTH_DATA),
    .p_AW    (p_FIFO_AW)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (tx_flush),
    .push      (wr_tx_data),
    .push_data (wdata),
    .pop       (tx_ready),
    .head      (tx_data),
    .count     (tx_cnt),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  // RX: fabric pushes with rx_valid, MCU pops through RX_DATA reads.
  fsmc_fifo_regbank_fifo #(
    .p_WIDTH (p_WIDTH_DATA),
    .p_AW    (p_FIFO_AW)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (rx_flush),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rd_rx_data),
    .head      (rx_head),
    .count     (rx_cnt),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

  // Registers.
  logic [p_WIDTH_DATA-1:0] scratch_q, scratch_d;
  logic [p_WIDTH_DATA-1:0] rdata_q, rdata_d;
  logic [p_WIDTH_DATA-1:0] rd_val;
  logic                    tx_ovf_q, tx_ovf_d;
  logic                    rx_udf_q, rx_udf_d;
  logic [1:0]              ctrl_ie;   // {IE_TXE, IE_RXNE} as seen by reads

  // Sticky error flags (W1C, a same-cycle set beats the clear) and scratch.
  always_comb begin
    tx_ovf_d  = (tx_ovf_q && !(wr_status && wdata[4])) || (wr_tx_data && tx_full);
    rx_udf_d  = (rx_udf_q && !(wr_status && wdata[5])) || (rd_rx_data && rx_empty);
    scratch_d = wr_scratch ? wdata : scratch_q;
  end

  // Read-data mux; unmapped and write-only addresses return zero.
  always_comb begin
    rd_val = '0;
    unique case (addr)
      ADDR_CTRL:     rd_val[3:2] = ctrl_ie;
      ADDR_STATUS:   rd_val[5:0] = {rx_udf_q, tx_ovf_q, rx_empty, rx_full, tx_empty, tx_full};
      ADDR_RX_DATA:  rd_val      = rx_empty ? '0 : rx_head;
      ADDR_TX_LEVEL: rd_val[p_FIFO_AW:0] = tx_cnt;
      ADDR_RX_LEVEL: rd_val[p_FIFO_AW:0] = rx_cnt;
      ADDR_SCRATCH:  rd_val      = scratch_q;
      default:       rd_val      = '0;
    endcase
    rdata_d = ren ? rd_val : rdata_q;
  end

  // Register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch_q <= '0;
      rdata_q   <= '0;
      tx_ovf_q  <= 1'b0;
      rx_udf_q  <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_udf_q  <= rx_udf_d;
    end
  end

  assign rdata = rdata_q;

`ifdef FSMC_REGBANK_IRQ_EN
  logic ie_rxne_q, ie_rxne_d;
  logic ie_txe_q, ie_txe_d;
  logic irq_q, irq_d;

  // Interrupt enables and the level interrupt, evaluated from registered state.
  always_comb begin
    ie_rxne_d = wr_ctrl ? wdata[2] : ie_rxne_q;
    ie_txe_d  = wr_ctrl ? wdata[3] : ie_txe_q;
    irq_d     = (ie_rxne_q && !rx_empty) || (ie_txe_q && tx_empty) || tx_ovf_q || rx_udf_q;
  end

  // Interrupt registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_rxne_q <= 1'b0;
      ie_txe_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ie_rxne_q <= ie_rxne_d;
      ie_txe_q  <= ie_txe_d;
      irq_q     <= irq_d;
    end
  end

  assign ctrl_ie = {ie_txe_q, ie_rxne_q};
  assign irq     = irq_q;
`else
  assign ctrl_ie = 2'b00;
  assign irq     = 1'b0;
`endif

endmodule

// File: tb/tb_fsmc_fifo_regbank.sv
// Self-checking bench for fsmc_fifo_regbank. A queue-based model of the
// register map tracks expected rdata, FIFO contents, sticky flags and irq.
`timescale 1ns/1ps
module tb_fsmc_fifo_regbank;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        wen;
  logic        ren;
  logic [15:0] rdata;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        irq;

  fsmc_fifo_regbank #(
    .p_WIDTH_ADDR (8),
    .p_WIDTH_DATA (16),
    .p_FIFO_AW    (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .wdata    (wdata),
    .wen      (wen),
    .ren      (ren),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model state.
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  bit          m_tx_ovf, m_rx_udf, m_ie_rxne, m_ie_txe, m_irq;
  logic [15:0] m_scratch, m_rdata;

  function automatic void model_reset();
    tx_q.delete();
    rx_q.delete();
    m_tx_ovf  = 0;
    m_rx_udf  = 0;
    m_ie_rxne = 0;
    m_ie_txe  = 0;
    m_irq     = 0;
    m_scratch = 16'h0;
    m_rdata   = 16'h0;
  endfunction

  // Applies the currently driven inputs for one clock edge, advances the model
  // from the pre-edge state, then compares every output 1ns after the edge.
  task automatic step();
    int          txn;
    int          rxn;
    logic [15:0] rd_v;
    bit          ovf_set;
    bit          udf_set;
    bit          irq_next;
    txn = tx_q.size();
    rxn = rx_q.size();
    irq_next = 0;
`ifdef FSMC_REGBANK_IRQ_EN
    irq_next = (m_ie_rxne && rxn != 0) || (m_ie_txe && txn == 0) || m_tx_ovf || m_rx_udf;
`endif
    if (ren) begin
      case (addr)
        8'h00:   rd_v = {12'h0, m_ie_txe, m_ie_rxne, 2'b00};
        8'h01:   rd_v = {10'h0, m_rx_udf, m_tx_ovf, rxn == 0, rxn == DEPTH, txn == 0, txn == DEPTH};
        8'h03:   rd_v = (rxn > 0) ? rx_q[0] : 16'h0;
        8'h04:   rd_v = 16'(txn);
        8'h05:   rd_v = 16'(rxn);
        8'h06:   rd_v = m_scratch;
        default: rd_v = 16'h0;
      endcase
      m_rdata = rd_v;
    end
    ovf_set = wen && addr == 8'h02 && txn == DEPTH;
    udf_set = ren && addr == 8'h03 && rxn == 0;
    if (tx_ready && txn > 0) void'(tx_q.pop_front());
    if (wen && addr == 8'h02 && txn < DEPTH) tx_q.push_back(wdata);
    if (ren && addr == 8'h03 && rxn > 0) void'(rx_q.pop_front());
    if (rx_valid && rxn < DEPTH) rx_q.push_back(rx_data);
    if (wen && addr == 8'h01) begin
      if (wdata[4]) m_tx_ovf = 0;
      if (wdata[5]) m_rx_udf = 0;
    end
    if (ovf_set) m_tx_ovf = 1;
    if (udf_set) m_rx_udf = 1;
    if (wen && addr == 8'h06) m_scratch = wdata;
    if (wen && addr == 8'h00) begin
      if (wdata[0]) tx_q.delete();
      if (wdata[1]) rx_q.delete();
`ifdef FSMC_REGBANK_IRQ_EN
      m_ie_rxne = wdata[2];
      m_ie_txe  = wdata[3];
`endif
    end
    m_irq = irq_next;

    @(posedge clk);
    #1;

    chk_cnt++;
    if (rdata !== m_rdata) $display("FAIL model_rdata: got %h expected %h", rdata, m_rdata);
    else pass_cnt++;
    chk_cnt++;
    if (tx_valid !== (tx_q.size() > 0)) $display("FAIL model_tx_valid: got %b expected %b", tx_valid, tx_q.size() > 0);
    else pass_cnt++;
    if (tx_q.size() > 0) begin
      chk_cnt++;
      if (tx_data !== tx_q[0]) $display("FAIL model_tx_data: got %h expected %h", tx_data, tx_q[0]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (rx_ready !== (rx_q.size() < DEPTH)) $display("FAIL model_rx_ready: got %b expected %b", rx_ready, rx_q.size() < DEPTH);
    else pass_cnt++;
    chk_cnt++;
    if (irq !== m_irq) $display("FAIL model_irq: got %b expected %b", irq, m_irq);
    else pass_cnt++;
  endtask

  task automatic mcu_write(input logic [7:0] a, input logic [15:0] d);
    wen = 1'b1; addr = a; wdata = d;
    step();
    wen = 1'b0;
  endtask

  task automatic mcu_read(input logic [7:0] a, output logic [15:0] d);
    ren = 1'b1; addr = a;
    step();
    ren = 1'b0;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    rst_n = 1'b1;
    wen = 0; ren = 0; addr = 0; wdata = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if ({rdata, tx_valid, rx_ready, irq} !== {16'h0, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_outputs: got rdata=%h tx_valid=%b rx_ready=%b irq=%b expected 0000 0 1 0", rdata, tx_valid, rx_ready, irq);
    else pass_cnt++;
    model_reset();
    rst_n = 1'b1;
    mcu_read(8'h01, d);
    chk_cnt++;
    if (d !== 16'h000A) $display("FAIL reset_status: got %h expected 000a", d);
    else pass_cnt++;
    mcu_read(8'h04, d);
    chk_cnt++;
    if (d !== 16'h0) $display("FAIL reset_tx_level: got %h expected 0000", d);
    else pass_cnt++;
    mcu_read(8'h00, d);
    chk_cnt++;
    if (d !== 16'h0) $display("FAIL reset_ctrl: got %h expected 0000", d);
    else pass_cnt++;
  endtask

  task automatic test_scratch();
    logic [15:0] d;
    mcu_write(8'h06, 16'hA5C3);
    ren = 1'b1; addr = 8'h06;
    chk_cnt++;
    if (rdata === 16'hA5C3) $display("FAIL scratch_early: got %h before the read edge", rdata);
    else pass_cnt++;
    step();
    ren = 1'b0;
    chk_cnt++;
    if (rdata !== 16'hA5C3) $display("FAIL scratch_read: got %h expected a5c3", rdata);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (rdata !== 16'hA5C3) $display("FAIL scratch_hold: got %h expected a5c3", rdata);
    else pass_cnt++;
    mcu_read(8'h7F, d);
    chk_cnt++;
    if (d !== 16'h0) $display("FAIL unmapped_read: got %h expected 0000", d);
    else pass_cnt++;
    // Differs from SCRATCH only in the top address bit.
    mcu_write(8'h86, 16'h1234);
    mcu_read(8'h06, d);
    chk_cnt++;
    if (d !== 16'hA5C3) $display("FAIL full_decode: got %h expected a5c3", d);
    else pass_cnt++;
    mcu_read(8'h02, d);
    chk_cnt++;
    if (d !== 16'h0) $display("FAIL tx_data_read: got %h expected 0000", d);
    else pass_cnt++;
  endtask

  task automatic test_tx_overflow();
    logic [15:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i <= 16; i++) mcu_write(8'h02, 16'(i));
    mcu_read(8'h04, d);
    chk_cnt++;
    if (d !== 16'd16) $display("FAIL tx_level_full: got %h expected 0010", d);
    else pass_cnt++;
    mcu_read(8'h01, d);
    chk_cnt++;
    if ({d[4], d[0]} !== 2'b11) $display("FAIL tx_full_ovf: got status %h expected b0=1 b4=1", d);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      chk_cnt++;
      if ({tx_valid, tx_data} !== {1'b1, 16'(i)})
        $display("FAIL tx_drain: got valid=%b data=%h expected 1 %h", tx_valid, tx_data, 16'(i));
      else pass_cnt++;
      tx_ready = 1'b1;
      step();
    end
    tx_ready = 1'b0;
    chk_cnt++;
    if (tx_valid !== 1'b0) $display("FAIL tx_drained: got tx_valid=%b expected 0", tx_valid);
    else pass_cnt++;
    mcu_write(8'h01, 16'h0010);
    mcu_read(8'h01, d);
    chk_cnt++;
    if (d !== 16'h000A) $display("FAIL tx_ovf_clear: got %h expected 000a", d);
    else pass_cnt++;
  endtask

  task automatic test_rx_underflow();
    logic [15:0] d;
    rx_valid = 1'b1; rx_data = 16'h1111;
    step();
    rx_data = 16'h2222;
    step();
    rx_valid = 1'b0;
    mcu_read(8'h03, d);
    chk_cnt++;
    if (d !== 16'h1111) $display("FAIL rx_pop0: got %h expected 1111", d);
    else pass_cnt++;
    mcu_read(8'h03, d);
    chk_cnt++;
    if (d !== 16'h2222) $display("FAIL rx_pop1: got %h expected 2222", d);
    else pass_cnt++;
    mcu_read(8'h03, d);
    chk_cnt++;
    if (d !== 16'h0) $display("FAIL rx_pop_empty: got %h expected 0000", d);
    else pass_cnt++;
    mcu_read(8'h01, d);
    chk_cnt++;
    if (d !== 16'h002A) $display("FAIL rx_udf_set: got %h expected 002a", d);
    else pass_cnt++;
    mcu_write(8'h01, 16'h0020);
    mcu_read(8'h01, d);
    chk_cnt++;
    if (d !== 16'h000A) $display("FAIL rx_udf_clear: got %h expected 000a", d);
    else pass_cnt++;
  endtask

  task automatic test_same_cycle_flush();
    logic [15:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) mcu_write(8'h02, 16'($urandom));
    mcu_read(8'h04, d);
    chk_cnt++;
    if (d !== 16'd5) $display("FAIL tx_level5: got %h expected 0005", d);
    else pass_cnt++;
    wen = 1'b1; addr = 8'h02; wdata = 16'hBEEF; tx_ready = 1'b1;
    step();
    wen = 1'b0; tx_ready = 1'b0;
    mcu_read(8'h04, d);
    chk_cnt++;
    if (d !== 16'd5) $display("FAIL push_pop_level: got %h expected 0005", d);
    else pass_cnt++;
    // Flush with a fabric pop requested in the same cycle: flush wins.
    tx_ready = 1'b1;
    mcu_write(8'h00, 16'h0001);
    tx_ready = 1'b0;
    mcu_read(8'h04, d);
    chk_cnt++;
    if (d !== 16'h0) $display("FAIL tx_flush: got %h expected 0000", d);
    else pass_cnt++;
    mcu_read(8'h00, d);
    chk_cnt++;
    if (d !== 16'h0) $display("FAIL flush_self_clear: got %h expected 0000", d);
    else pass_cnt++;
    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = 16'($urandom);
      step();
    end
    // Flush with a fabric push in the same cycle: flush wins.
    mcu_write(8'h00, 16'h0002);
    rx_valid = 1'b0;
    mcu_read(8'h05, d);
    chk_cnt++;
    if (d !== 16'h0) $display("FAIL rx_flush: got %h expected 0000", d);
    else pass_cnt++;
  endtask

`ifdef FSMC_REGBANK_IRQ_EN
  task automatic test_irq();
    logic [15:0] d;
    mcu_write(8'h00, 16'h0004);
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_idle: got %b expected 0", irq);
    else pass_cnt++;
    rx_valid = 1'b1; rx_data = 16'h5A5A;
    step();
    rx_valid = 1'b0;
    chk_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_latency: got %b expected 0", irq);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_rxne: got %b expected 1", irq);
    else pass_cnt++;
    mcu_read(8'h03, d);
    step();
    chk_cnt++;
    if ({d, irq} !== {16'h5A5A, 1'b0}) $display("FAIL irq_cleared: got data=%h irq=%b expected 5a5a 0", d, irq);
    else pass_cnt++;
    mcu_write(8'h00, 16'h0008);
    step();
    mcu_read(8'h00, d);
    chk_cnt++;
    if ({d, irq} !== {16'h0008, 1'b1}) $display("FAIL irq_txe: got ctrl=%h irq=%b expected 0008 1", d, irq);
    else pass_cnt++;
    mcu_write(8'h00, 16'h0000);
    step();
  endtask
`endif

  task automatic test_random();
    int op;
    for (int i = 0; i < 800; i++) begin
      op = $urandom_range(0, 10);
      tx_ready = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rx_valid = (i < 400) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
      rx_data  = 16'($urandom);
      wen = 1'b0; ren = 1'b0;
      case (op)
        0, 1, 2: begin wen = 1'b1; addr = 8'h02; wdata = 16'($urandom); end
        3, 4:    begin ren = 1'b1; addr = 8'h03; end
        5:       begin ren = 1'b1; addr = 8'h01; end
        6:       begin ren = 1'b1; addr = 8'($urandom_range(4, 5)); end
        7:       begin ren = 1'b1; addr = 8'($urandom); end
        8: begin
          if ($urandom_range(0, 5) == 0) begin
            wen = 1'b1; addr = 8'h00; wdata = 16'($urandom_range(0, 15));
          end else begin
            wen = 1'b1; addr = 8'h01; wdata = 16'($urandom);
          end
        end
        9:       begin wen = 1'b1; addr = 8'($urandom); wdata = 16'($urandom); end
        default: ;
      endcase
      step();
    end
    wen = 1'b0; ren = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic test_reset_mid_traffic();
    logic [15:0] d;
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = 16'($urandom);
      mcu_write(8'h02, 16'($urandom));
    end
    mcu_read(8'h06, d);
    rst_n = 1'b0;
    #2;
    chk_cnt++;
    if ({rdata, tx_valid, rx_ready, irq} !== {16'h0, 1'b0, 1'b1, 1'b0})
      $display("FAIL midreset_outputs: got rdata=%h tx_valid=%b rx_ready=%b irq=%b expected 0000 0 1 0", rdata, tx_valid, rx_ready, irq);
    else pass_cnt++;
    rx_valid = 1'b0; wen = 1'b0; ren = 1'b0; tx_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    mcu_read(8'h01, d);
    chk_cnt++;
    if (d !== 16'h000A) $display("FAIL midreset_status: got %h expected 000a", d);
    else pass_cnt++;
    mcu_read(8'h04, d);
    chk_cnt++;
    if (d !== 16'h0) $display("FAIL midreset_tx_level: got %h expected 0000", d);
    else pass_cnt++;
    mcu_read(8'h05, d);
    chk_cnt++;
    if (d !== 16'h0) $display("FAIL midreset_rx_level: got %h expected 0000", d);
    else pass_cnt++;
    mcu_read(8'h06, d);
    chk_cnt++;
    if (d !== 16'h0) $display("FAIL midreset_scratch: got %h expected 0000", d);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_scratch();
    test_tx_overflow();
    test_rx_underflow();
    test_same_cycle_flush();
`ifdef FSMC_REGBANK_IRQ_EN
    test_irq();
`endif
    test_random();
    test_reset_mid_traffic();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
